// File: rtl/lsu_split_if.sv
// lsu_split_if: core request/response, memory channel and perf counters of the load/store unit.
// The master modport is the unit's side; slave is the core/memory side.
interface lsu_split_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int PERF_W = 32
);
    logic                req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]          req_size;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                resp_valid, resp_fault;
    logic [DATA_W-1:0]   resp_rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_read, mem_write, mem_req_ack, mem_rdata_valid, mem_rdata_ack;
    logic [DATA_W-1:0]   mem_wdata, mem_rdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [PERF_W-1:0]   perf_mem_cycles, perf_split;

    modport master (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
               mem_req_ack, mem_rdata, mem_rdata_valid,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_read, mem_write,
               mem_wdata, mem_wstrb, mem_rdata_ack, perf_mem_cycles, perf_split
    );
    modport slave (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
               mem_req_ack, mem_rdata, mem_rdata_valid,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_read, mem_write,
               mem_wdata, mem_wstrb, mem_rdata_ack, perf_mem_cycles, perf_split
    );
endinterface

// File: rtl/lsu_split_unit.sv
// lsu_split_unit: load/store unit with byte strobes, load extension and splitting of
// word-boundary-crossing accesses into two memory beats (or faulting on them).
module lsu_split_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1,
    parameter int PERF_W         = 32
) (
    input logic         clk,
    input logic         rst,
    lsu_split_if.master bus
);
    localparam int B  = DATA_W / 8;
    localparam int OB = $clog2(B);
    localparam int B2 = 2 * B;
    typedef enum logic [1:0] {IDLE, REQ, RDW, RESP} state_e;
    state_e              state_q, state_d;
    logic                beat_q, beat_d, wen_q, uns_q, cross_q, fault_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q, base;
    logic [DATA_W-1:0]   wdata_q, mdata, res;
    logic [2*DATA_W-1:0] asm_q, wide_data, sh;
    logic [B2-1:0]       wide_strb;
    logic [OB-1:0]       off_q, req_off;
    logic [3:0]          n_q, req_n;
    logic [PERF_W-1:0]   mem_cyc_q, split_q;
    logic                accept, cross_i, illegal_i, fault_i, sign, in_req, last;

    assign req_n     = 4'd1 << bus.req_size;
    assign req_off   = bus.req_addr[OB-1:0];
    assign cross_i   = 5'(req_off) + 5'(req_n) > 5'(B);
    assign illegal_i = bus.req_size > 2'(OB);
    assign fault_i   = illegal_i || (cross_i && MISALIGN_SPLIT == 0);
    assign accept    = bus.req_valid && state_q == IDLE;
    assign off_q     = addr_q[OB-1:0];
    assign n_q       = 4'd1 << size_q;
    assign base      = {addr_q[ADDR_W-1:OB], {OB{1'b0}}};
    assign in_req    = state_q == REQ;
    assign last      = !(cross_q && !beat_q);

    // Store lanes and load extraction both work on a two-beat-wide window.
    always_comb begin
        mdata = '0;
        res   = '0;
        sign  = 1'b0;
        for (int i = 0; i < DATA_W; i++) mdata[i] = (i < 8 * int'(n_q)) ? wdata_q[i] : 1'b0;
        wide_data = {{DATA_W{1'b0}}, mdata} << {off_q, 3'b000};
        wide_strb = B2'((1 << n_q) - 1) << off_q;
        sh        = asm_q >> {off_q, 3'b000};
        for (int i = 0; i < DATA_W; i++) if (i == 8 * int'(n_q) - 1) sign = sh[i];
        for (int i = 0; i < DATA_W; i++) res[i] = (i < 8 * int'(n_q)) ? sh[i] : (sign && !uns_q);
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = fault_i ? RESP : REQ;
                beat_d  = 1'b0;
            end
            REQ: if (bus.mem_req_ack) begin
                state_d = !wen_q ? RDW : last ? RESP : REQ;
                beat_d  = beat_q || (wen_q && !last);
            end
            RDW: if (bus.mem_rdata_valid) begin
                state_d = last ? RESP : REQ;
                beat_d  = beat_q || !last;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready       = state_q == IDLE;
    assign bus.mem_read        = in_req && !wen_q;
    assign bus.mem_write       = in_req && wen_q;
    assign bus.mem_addr        = !in_req ? '0 : beat_q ? base + ADDR_W'(B) : base;
    assign bus.mem_wdata       = !(in_req && wen_q) ? '0 : beat_q ? wide_data[2*DATA_W-1:DATA_W] : wide_data[DATA_W-1:0];
    assign bus.mem_wstrb       = !(in_req && wen_q) ? '0 : beat_q ? wide_strb[B2-1:B] : wide_strb[B-1:0];
    assign bus.mem_rdata_ack   = state_q == RDW;
    assign bus.resp_valid      = state_q == RESP;
    assign bus.resp_fault      = state_q == RESP && fault_q;
    assign bus.resp_rdata      = (state_q == RESP && !wen_q && !fault_q) ? res : '0;
    assign bus.perf_mem_cycles = mem_cyc_q;
    assign bus.perf_split      = split_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= 1'b0;
            wen_q     <= 1'b0;
            uns_q     <= 1'b0;
            cross_q   <= 1'b0;
            fault_q   <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            asm_q     <= '0;
            mem_cyc_q <= '0;
            split_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (accept) begin
                wen_q   <= bus.req_wen;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                cross_q <= cross_i;
                fault_q <= fault_i;
                if (cross_i && MISALIGN_SPLIT != 0 && !illegal_i) split_q <= split_q + 1'b1;
            end
            if (state_q == REQ || state_q == RDW) mem_cyc_q <= mem_cyc_q + 1'b1;
            if (state_q == RDW && bus.mem_rdata_valid) begin
                if (beat_q) asm_q[2*DATA_W-1:DATA_W] <= bus.mem_rdata;
                else asm_q[DATA_W-1:0] <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_lsu_split_unit.sv
// tb_lsu_split_unit: directed tests of lsu_split_unit, one splitting instance (b1)
// and one faulting instance (b0), both 32-bit.
module tb_lsu_split_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    lsu_split_if #(.DATA_W(32), .ADDR_W(32), .PERF_W(32)) b1 ();
    lsu_split_if #(.DATA_W(32), .ADDR_W(32), .PERF_W(32)) b0 ();

    lsu_split_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1), .PERF_W(32)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
    lsu_split_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(0), .PERF_W(32)) dut0 (.clk(clk), .rst(rst), .bus(b0.master));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wen, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        b1.req_wen = wen;
        b1.req_size = size;
        b1.req_unsigned = uns;
        b1.req_addr = addr;
        b1.req_wdata = wdata;
        b1.req_valid = 1'b1;
        cyc();
        b1.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!b1.resp_valid && lat < 20) begin
            cyc();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++; if (b1.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %h exp 1", b1.req_ready); end
        checks++; if ({b1.resp_valid, b1.resp_fault, b1.mem_read, b1.mem_write, b1.mem_rdata_ack} !== 5'b0) begin failures++; $display("FAIL reset_ctl got %b exp 00000", {b1.resp_valid, b1.resp_fault, b1.mem_read, b1.mem_write, b1.mem_rdata_ack}); end
        checks++; if ({b1.mem_addr, b1.mem_wdata, b1.resp_rdata} !== 96'h0) begin failures++; $display("FAIL reset_data got %h exp 0", {b1.mem_addr, b1.mem_wdata, b1.resp_rdata}); end
        checks++; if ({b1.perf_mem_cycles, b1.perf_split} !== 64'h0) begin failures++; $display("FAIL reset_perf got %h exp 0", {b1.perf_mem_cycles, b1.perf_split}); end
        checks++; if (b0.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready0 got %h exp 1", b0.req_ready); end
    endtask

    task automatic test_load_word();
        int lat;
        b1.mem_req_ack = 1'b1;
        b1.mem_rdata_valid = 1'b1;
        b1.mem_rdata = 32'hDEADBEEF;
        send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        checks++; if (b1.mem_addr !== 32'h100) begin failures++; $display("FAIL lw_addr got %h exp 100", b1.mem_addr); end
        checks++; if ({b1.mem_read, b1.mem_write, b1.mem_wstrb} !== 6'b100000) begin failures++; $display("FAIL lw_req got %b exp 100000", {b1.mem_read, b1.mem_write, b1.mem_wstrb}); end
        wait_resp(lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL lw_latency got %0d exp 3", lat); end
        checks++; if (b1.resp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got %h exp deadbeef", b1.resp_rdata); end
        checks++; if (b1.resp_fault !== 1'b0) begin failures++; $display("FAIL lw_fault got %h exp 0", b1.resp_fault); end
        cyc();
        checks++; if ({b1.resp_valid, b1.req_ready, b1.resp_rdata} !== {2'b01, 32'h0}) begin failures++; $display("FAIL lw_after got %h exp %h", {b1.resp_valid, b1.req_ready, b1.resp_rdata}, {2'b01, 32'h0}); end
    endtask

    task automatic test_load_byte();
        int lat;
        b1.mem_rdata = 32'h80FF1234;
        send(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        checks++; if (b1.mem_addr !== 32'h100) begin failures++; $display("FAIL lb_addr got %h exp 100", b1.mem_addr); end
        wait_resp(lat);
        checks++; if (b1.resp_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got %h exp ffffff80", b1.resp_rdata); end
        cyc();
        send(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        wait_resp(lat);
        checks++; if (b1.resp_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_data got %h exp 00000080", b1.resp_rdata); end
        cyc();
        send(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        wait_resp(lat);
        checks++; if (b1.resp_rdata !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_data got %h exp ffff80ff", b1.resp_rdata); end
        cyc();
        send(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
        wait_resp(lat);
        checks++; if (b1.resp_rdata !== 32'h00001234) begin failures++; $display("FAIL lhu_data got %h exp 00001234", b1.resp_rdata); end
        cyc();
    endtask

    task automatic test_store_half();
        int lat;
        send(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD);
        checks++; if ({b1.mem_read, b1.mem_write} !== 2'b01) begin failures++; $display("FAIL sh_req got %b exp 01", {b1.mem_read, b1.mem_write}); end
        checks++; if (b1.mem_addr !== 32'h100) begin failures++; $display("FAIL sh_addr got %h exp 100", b1.mem_addr); end
        checks++; if (b1.mem_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_strb got %b exp 1100", b1.mem_wstrb); end
        checks++; if (b1.mem_wdata !== 32'hABCD0000) begin failures++; $display("FAIL sh_wdata got %h exp abcd0000", b1.mem_wdata); end
        wait_resp(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL sh_latency got %0d exp 2", lat); end
        checks++; if (b1.resp_rdata !== 32'h0) begin failures++; $display("FAIL sh_rdata got %h exp 0", b1.resp_rdata); end
        cyc();
    endtask

    task automatic test_split_store();
        logic [31:0] ps;
        ps = b1.perf_split;
        send(1'b1, 2'd2, 1'b0, 32'h103, 32'h11223344);
        checks++; if ({b1.mem_addr, b1.mem_wstrb, b1.mem_wdata} !== {32'h100, 4'b1000, 32'h44000000}) begin failures++; $display("FAIL sw_beat0 got %h exp %h", {b1.mem_addr, b1.mem_wstrb, b1.mem_wdata}, {32'h100, 4'b1000, 32'h44000000}); end
        cyc();
        checks++; if ({b1.mem_addr, b1.mem_wstrb, b1.mem_wdata} !== {32'h104, 4'b0111, 32'h00112233}) begin failures++; $display("FAIL sw_beat1 got %h exp %h", {b1.mem_addr, b1.mem_wstrb, b1.mem_wdata}, {32'h104, 4'b0111, 32'h00112233}); end
        cyc();
        checks++; if ({b1.resp_valid, b1.resp_fault, b1.resp_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL sw_resp got %h exp %h", {b1.resp_valid, b1.resp_fault, b1.resp_rdata}, {2'b10, 32'h0}); end
        checks++; if (b1.perf_split !== ps + 32'd1) begin failures++; $display("FAIL sw_perf_split got %0d exp %0d", b1.perf_split, ps + 32'd1); end
        cyc();
        send(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h11223344);
        checks++; if ({b1.mem_addr, b1.mem_wstrb, b1.mem_wdata} !== {32'hFFFFFFFC, 4'b1100, 32'h33440000}) begin failures++; $display("FAIL wrap_beat0 got %h exp %h", {b1.mem_addr, b1.mem_wstrb, b1.mem_wdata}, {32'hFFFFFFFC, 4'b1100, 32'h33440000}); end
        cyc();
        checks++; if ({b1.mem_addr, b1.mem_wstrb, b1.mem_wdata} !== {32'h0, 4'b0011, 32'h00001122}) begin failures++; $display("FAIL wrap_beat1 got %h exp %h", {b1.mem_addr, b1.mem_wstrb, b1.mem_wdata}, {32'h0, 4'b0011, 32'h00001122}); end
        cyc();
        cyc();
    endtask

    task automatic test_split_load();
        int lat;
        logic [31:0] pm, ps;
        b1.mem_req_ack = 1'b1;
        b1.mem_rdata_valid = 1'b1;
        b1.mem_rdata = 32'h44332211;
        send(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
        wait_resp(lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL split_lw_latency got %0d exp 5", lat); end
        checks++; if (b1.resp_rdata !== 32'h22114433) begin failures++; $display("FAIL split_lw0_data got %h exp 22114433", b1.resp_rdata); end
        cyc();
        b1.mem_req_ack = 1'b0;
        b1.mem_rdata_valid = 1'b0;
        pm = b1.perf_mem_cycles;
        ps = b1.perf_split;
        send(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0);
        b1.req_addr = 32'h300;
        b1.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({b1.mem_addr, b1.mem_read, b1.req_ready} !== {32'hFC, 2'b10}) begin failures++; $display("FAIL stall_req%0d got %h exp %h", i, {b1.mem_addr, b1.mem_read, b1.req_ready}, {32'hFC, 2'b10}); end
            cyc();
        end
        b1.req_valid = 1'b0;
        b1.mem_req_ack = 1'b1;
        cyc();
        checks++; if ({b1.mem_rdata_ack, b1.mem_read, b1.mem_addr} !== {2'b10, 32'h0}) begin failures++; $display("FAIL split_rdw0 got %h exp %h", {b1.mem_rdata_ack, b1.mem_read, b1.mem_addr}, {2'b10, 32'h0}); end
        b1.mem_req_ack = 1'b0;
        b1.mem_rdata_valid = 1'b1;
        b1.mem_rdata = 32'hAAAA0000;
        cyc();
        checks++; if ({b1.mem_addr, b1.mem_read} !== {32'h100, 1'b1}) begin failures++; $display("FAIL split_beat1 got %h exp %h", {b1.mem_addr, b1.mem_read}, {32'h100, 1'b1}); end
        b1.mem_rdata_valid = 1'b0;
        b1.mem_req_ack = 1'b1;
        cyc();
        b1.mem_req_ack = 1'b0;
        b1.mem_rdata_valid = 1'b1;
        b1.mem_rdata = 32'h0000BBBB;
        cyc();
        checks++; if ({b1.resp_valid, b1.resp_rdata} !== {1'b1, 32'hBBBBAAAA}) begin failures++; $display("FAIL split_lw1_data got %h exp %h", {b1.resp_valid, b1.resp_rdata}, {1'b1, 32'hBBBBAAAA}); end
        checks++; if (b1.perf_mem_cycles !== pm + 32'd7) begin failures++; $display("FAIL perf_mem got %0d exp %0d", b1.perf_mem_cycles, pm + 32'd7); end
        checks++; if (b1.perf_split !== ps + 32'd1) begin failures++; $display("FAIL perf_split got %0d exp %0d", b1.perf_split, ps + 32'd1); end
        b1.mem_rdata_valid = 1'b0;
        cyc();
        checks++; if ({b1.req_ready, b1.mem_read, b1.resp_valid} !== 3'b100) begin failures++; $display("FAIL busy_ignored got %b exp 100", {b1.req_ready, b1.mem_read, b1.resp_valid}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        b1.mem_req_ack = 1'b1;
        b1.mem_rdata_valid = 1'b1;
        send(1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADF00D);
        cyc();
        checks++; if ({b1.resp_valid, b1.req_ready} !== 2'b10) begin failures++; $display("FAIL b2b_resp got %b exp 10", {b1.resp_valid, b1.req_ready}); end
        send(1'b1, 2'd0, 1'b0, 32'h45, 32'h000000EE);
        checks++; if ({b1.mem_write, b1.mem_addr} !== {1'b0, 32'h0}) begin failures++; $display("FAIL b2b_in_resp got %h exp %h", {b1.mem_write, b1.mem_addr}, {1'b0, 32'h0}); end
        send(1'b1, 2'd0, 1'b0, 32'h45, 32'h000000EE);
        checks++; if ({b1.mem_write, b1.mem_addr, b1.mem_wstrb, b1.mem_wdata} !== {1'b1, 32'h44, 4'b0010, 32'h0000EE00}) begin failures++; $display("FAIL b2b_sb got %h exp %h", {b1.mem_write, b1.mem_addr, b1.mem_wstrb, b1.mem_wdata}, {1'b1, 32'h44, 4'b0010, 32'h0000EE00}); end
        wait_resp(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_latency got %0d exp 2", lat); end
        cyc();
    endtask

    task automatic test_fault();
        int lat;
        logic [31:0] pm;
        b0.mem_req_ack = 1'b1;
        b0.mem_rdata_valid = 1'b1;
        b0.mem_rdata = 32'h80FF1234;
        pm = b0.perf_mem_cycles;
        b0.req_wen = 1'b0;
        b0.req_size = 2'd2;
        b0.req_unsigned = 1'b0;
        b0.req_addr = 32'h101;
        b0.req_valid = 1'b1;
        cyc();
        b0.req_valid = 1'b0;
        checks++; if ({b0.resp_valid, b0.resp_fault, b0.mem_read, b0.resp_rdata} !== {3'b110, 32'h0}) begin failures++; $display("FAIL fault_resp got %h exp %h", {b0.resp_valid, b0.resp_fault, b0.mem_read, b0.resp_rdata}, {3'b110, 32'h0}); end
        checks++; if ({b0.perf_mem_cycles, b0.perf_split} !== {pm, 32'h0}) begin failures++; $display("FAIL fault_perf got %h exp %h", {b0.perf_mem_cycles, b0.perf_split}, {pm, 32'h0}); end
        cyc();
        checks++; if ({b0.resp_fault, b0.req_ready} !== 2'b01) begin failures++; $display("FAIL fault_after got %b exp 01", {b0.resp_fault, b0.req_ready}); end
        b0.req_size = 2'd1;
        b0.req_valid = 1'b1;
        cyc();
        b0.req_valid = 1'b0;
        lat = 1;
        while (!b0.resp_valid && lat < 20) begin
            cyc();
            lat++;
        end
        checks++; if ({lat[3:0], b0.resp_fault, b0.resp_rdata} !== {4'd3, 1'b0, 32'hFFFFFF12}) begin failures++; $display("FAIL nocross_lh got %h exp %h", {lat[3:0], b0.resp_fault, b0.resp_rdata}, {4'd3, 1'b0, 32'hFFFFFF12}); end
        cyc();
        send(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        checks++; if ({b1.resp_valid, b1.resp_fault, b1.mem_read} !== 3'b110) begin failures++; $display("FAIL illegal_size got %b exp 110", {b1.resp_valid, b1.resp_fault, b1.mem_read}); end
        cyc();
    endtask

    task automatic test_reset_mid();
        b1.mem_req_ack = 1'b1;
        b1.mem_rdata_valid = 1'b0;
        send(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        cyc();
        checks++; if (b1.mem_rdata_ack !== 1'b1) begin failures++; $display("FAIL rst_rdw got %h exp 1", b1.mem_rdata_ack); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if ({b1.req_ready, b1.resp_valid, b1.mem_rdata_ack} !== 3'b100) begin failures++; $display("FAIL rst_mid_ctl got %b exp 100", {b1.req_ready, b1.resp_valid, b1.mem_rdata_ack}); end
        checks++; if ({b1.perf_mem_cycles, b1.perf_split} !== 64'h0) begin failures++; $display("FAIL rst_mid_perf got %h exp 0", {b1.perf_mem_cycles, b1.perf_split}); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (b1.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_no_resp%0d got %h exp 0", i, b1.resp_valid); end
        end
        b1.mem_req_ack = 1'b0;
        send(1'b1, 2'd2, 1'b0, 32'h200, 32'h5);
        checks++; if (b1.mem_write !== 1'b1) begin failures++; $display("FAIL rst_req_pre got %h exp 1", b1.mem_write); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if ({b1.mem_write, b1.mem_wstrb, b1.req_ready} !== 6'b000001) begin failures++; $display("FAIL rst_req_drop got %b exp 000001", {b1.mem_write, b1.mem_wstrb, b1.req_ready}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.req_valid = 1'b0; b1.req_wen = 1'b0; b1.req_size = 2'd0; b1.req_unsigned = 1'b0;
        b1.req_addr = '0; b1.req_wdata = '0; b1.mem_req_ack = 1'b0; b1.mem_rdata = '0; b1.mem_rdata_valid = 1'b0;
        b0.req_valid = 1'b0; b0.req_wen = 1'b0; b0.req_size = 2'd0; b0.req_unsigned = 1'b0;
        b0.req_addr = '0; b0.req_wdata = '0; b0.mem_req_ack = 1'b0; b0.mem_rdata = '0; b0.mem_rdata_valid = 1'b0;
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_split_store();
        test_split_load();
        test_back_to_back();
        test_fault();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
